bcd_counter: RTL

- Multi-digit decimal up/down counter with built-in prescaler; drives the per-digit 7-segment decoders of the display path.
- Each 4-bit digit slice of `digits` feeds one 7-segment decoder instance directly.
- Every digit is guaranteed to be in the range 0-9, so the decoders never show hex glyphs.
- Provides enable, direction, synchronous clear, parallel load, and single-cycle step/rollover pulses for chaining or status.

---
 rtl/bcd_counter.sv | 116 +++++++++++
 1 files changed

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with an internal prescaler.
// Every stored digit is kept in 0-9 so downstream 7-segment decoders never see hex codes.
module bcd_counter #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tick,
  output logic                  rollover
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

  logic [W-1:0]  digits_q, digits_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          tick_q, tick_d;
  logic          roll_q, roll_d;

  logic [W-1:0]  stepped_c;
  logic [W-1:0]  sanitized_c;
  logic          wrap_c;
  logic          carry_c;
  logic [3:0]    dig_c;

  // One decimal step in the selected direction; carry/borrow ripples through all digits.
  always_comb begin
    stepped_c = digits_q;
    carry_c   = 1'b1;
    dig_c     = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_c = digits_q[4*i +: 4];
      if (carry_c) begin
        if (up) begin
          if (dig_c >= 4'd9) begin
            stepped_c[4*i +: 4] = 4'd0;
          end else begin
            stepped_c[4*i +: 4] = dig_c + 4'd1;
            carry_c             = 1'b0;
          end
        end else begin
          if (dig_c == 4'd0) begin
            stepped_c[4*i +: 4] = 4'd9;
          end else begin
            stepped_c[4*i +: 4] = dig_c - 4'd1;
            carry_c             = 1'b0;
          end
        end
      end
    end
    wrap_c = carry_c;
  end

  // Loaded digits above 9 are forced to 0 so the count never holds an invalid code.
  always_comb begin
    sanitized_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        sanitized_c[4*i +: 4] = 4'd0;
      end else begin
        sanitized_c[4*i +: 4] = load_val[4*i +: 4];
      end
    end
  end

  // Priority: clear, then load, then prescaled step, else hold.
  always_comb begin
    digits_d = digits_q;
    psc_d    = psc_q;
    tick_d   = 1'b0;
    roll_d   = 1'b0;
    if (clr) begin
      digits_d = '0;
      psc_d    = '0;
    end else if (load) begin
      digits_d = sanitized_c;
      psc_d    = '0;
    end else if (en) begin
      if (psc_q == PSC_LAST) begin
        psc_d    = '0;
        digits_d = stepped_c;
        tick_d   = 1'b1;
        roll_d   = wrap_c;
      end else begin
        psc_d = psc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digits_q <= '0;
      psc_q    <= '0;
      tick_q   <= 1'b0;
      roll_q   <= 1'b0;
    end else begin
      digits_q <= digits_d;
      psc_q    <= psc_d;
      tick_q   <= tick_d;
      roll_q   <= roll_d;
    end
  end

  assign digits   = digits_q;
  assign tick     = tick_q;
  assign rollover = roll_q;

endmodule
